// File: rtl/prio_pkg.sv
// Shared definitions for the registered priority encoder / round-robin arbiter.
// Mode encoding and the round-robin search mask helper live here.
package prio_pkg;

  localparam int unsigned PRIO_MAX_N = 64;

  typedef enum logic {
    PRIO_FIXED = 1'b0,
    PRIO_RR    = 1'b1
  } prio_mode_e;

  // Bit i set when index i lies strictly below ptr (and inside the n-wide vector).
  function automatic logic [PRIO_MAX_N-1:0] rr_order_mask(input int unsigned ptr,
                                                          input int unsigned n);
    logic [PRIO_MAX_N-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < PRIO_MAX_N; i++) begin
      m[i] = (i < ptr) && (i < n);
    end
    return m;
  endfunction

endpackage

// File: rtl/prio_enc_n.sv
// Combinational highest-set-bit encoder: N-bit vector to W-bit index plus any-set flag.
module prio_enc_n #(
  parameter int unsigned N = 8,
  parameter int unsigned W = $clog2(N)
) (
  input  logic [N-1:0] i_vec,
  output logic [W-1:0] o_idx,
  output logic         o_any
);

  // NOTE: defaults first so every path assigns the outputs and no latch is inferred.
  always_comb begin
    o_idx = '0;
    o_any = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (i_vec[i]) begin
        o_idx = W'(i);
        o_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/prio_arb_rr.sv
// Registered N-input priority arbiter, fixed or round-robin, with a valid/ready output.
// Outputs come straight from flops; only o_ready reaches the load enable combinationally.
module prio_arb_rr
  import prio_pkg::*;
#(
  parameter int unsigned N = 8,
  parameter int unsigned W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         mode,
  input  logic         o_ready,
  output logic [W-1:0] q,
  output logic [N-1:0] gnt,
  output logic         v
);

  logic [W-1:0] r_q;
  logic [N-1:0] r_gnt;
  logic         r_v;
  logic [W-1:0] r_ptr;

  logic                  w_accept;
  logic                  w_load;
  logic                  w_rr;
  logic [W-1:0]          w_p;
  logic [PRIO_MAX_N-1:0] w_mask_full;
  logic [N-1:0]          w_mask;
  logic [W-1:0]          w_m_idx;
  logic                  w_m_any;
  logic [W-1:0]          w_f_idx;
  logic                  w_f_any;
  logic [W-1:0]          w_idx;

  assign w_accept = r_v && o_ready;
  assign w_load   = !r_v || o_ready;
  assign w_rr     = (prio_mode_e'(mode) == PRIO_RR);

  // A grant accepted this cycle already counts as the pointer for the new search.
  assign w_p         = (w_accept && w_rr) ? r_q : r_ptr;
  assign w_mask_full = rr_order_mask(32'(w_p), N);
  assign w_mask      = w_mask_full[N-1:0];

  prio_enc_n #(.N(N), .W(W)) u_enc_masked (
    .i_vec (req & w_mask),
    .o_idx (w_m_idx),
    .o_any (w_m_any)
  );

  prio_enc_n #(.N(N), .W(W)) u_enc_full (
    .i_vec (req),
    .o_idx (w_f_idx),
    .o_any (w_f_any)
  );

  // Nothing below the pointer: the unmasked search yields N-1 down to p.
  assign w_idx = (w_rr && w_m_any) ? w_m_idx : w_f_idx;

  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q   <= '0;
      r_gnt <= '0;
      r_v   <= 1'b0;
      r_ptr <= '0;
    end else begin
      if (w_load) begin
        r_v   <= w_f_any;
        r_q   <= w_f_any ? w_idx : '0;
        r_gnt <= w_f_any ? (N'(1) << w_idx) : '0;
      end
      if (w_accept && w_rr) begin
        r_ptr <= r_q;
      end
    end
  end

  assign q   = r_q;
  assign gnt = r_gnt;
  assign v   = r_v;

endmodule

// File: tb/tb_prio_arb_rr.sv
// Self-checking bench for prio_arb_rr: directed scenarios plus randomized traffic
// compared against a search-order reference model.
module tb_prio_arb_rr;

  localparam int N = 8;
  localparam int W = 3;

  logic         clk;
  logic         rst;
  logic [N-1:0] req;
  logic         mode;
  logic         o_ready;
  logic [W-1:0] q;
  logic [N-1:0] gnt;
  logic         v;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  int m_q   = 0;
  int m_ptr = 0;
  bit m_v   = 0;

  prio_arb_rr #(.N(N)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .mode    (mode),
    .o_ready (o_ready),
    .q       (q),
    .gnt     (gnt),
    .v       (v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W+N:0] pack(input int eq, input bit ev);
    logic [N-1:0] g;
    g = ev ? (N'(1) << eq) : '0;
    return {W'(eq), g, ev};
  endfunction

  function automatic void model_reset();
    m_q   = 0;
    m_v   = 0;
    m_ptr = 0;
  endfunction

  // Next state from the arbitration rules: search order p-1, p-2, ... wrapping to p.
  function automatic void model_step(input logic [N-1:0] r, input logic md, input logic rdy);
    bit accepted;
    bit load;
    int p;
    int idx;
    bit found;
    accepted = m_v && rdy;
    load     = !m_v || rdy;
    p        = (accepted && md) ? m_q : m_ptr;
    if (accepted && md) m_ptr = m_q;
    if (load) begin
      found = 0;
      idx   = 0;
      for (int k = 1; k <= N; k++) begin
        int cand;
        cand = ((md ? p : 0) - k + N) % N;
        if (!found && r[cand]) begin
          found = 1;
          idx   = cand;
        end
      end
      m_v = found;
      m_q = found ? idx : 0;
    end
  endfunction

  task automatic drive_cycle(input logic [N-1:0] r, input logic md, input logic rdy);
    req     = r;
    mode    = md;
    o_ready = rdy;
    model_step(r, md, rdy);
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    logic [W+N:0] exp;
    #1;
    n_cmp++;
    if ({q, gnt, v} !== pack(0, 0)) begin
      n_bad++;
      $display("FAIL reset_initial: got q=%0d gnt=%h v=%b, want 0/00/0", q, gnt, v);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      drive_cycle(8'hFF, 1'b1, 1'b1);
      exp = pack(7 - i, 1);
      n_cmp++;
      if ({q, gnt, v} !== exp) begin
        n_bad++;
        $display("FAIL reset_prefill[%0d]: got q=%0d gnt=%h v=%b, want q=%0d v=1", i, q, gnt, v, 7 - i);
      end
    end
    // Mid-cycle assertion with v=1 and a non-zero pointer; outputs must clear before any edge.
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({q, gnt, v} !== pack(0, 0)) begin
      n_bad++;
      $display("FAIL reset_async: got q=%0d gnt=%h v=%b, want 0/00/0", q, gnt, v);
    end
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive_cycle(8'hFF, 1'b1, 1'b1);
    n_cmp++;
    if ({q, gnt, v} !== pack(7, 1)) begin
      n_bad++;
      $display("FAIL reset_first_rr: got q=%0d gnt=%h v=%b, want q=7 gnt=80 v=1", q, gnt, v);
    end
  endtask

  task automatic test_fixed();
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      drive_cycle(8'b0010_0110, 1'b0, 1'b1);
      n_cmp++;
      if ({q, gnt, v} !== pack(5, 1)) begin
        n_bad++;
        $display("FAIL fixed[%0d]: got q=%0d gnt=%h v=%b, want q=5 gnt=20 v=1", i, q, gnt, v);
      end
    end
  endtask

  task automatic test_rr_rotation();
    apply_reset();
    for (int i = 0; i < 9; i++) begin
      drive_cycle(8'hFF, 1'b1, 1'b1);
      n_cmp++;
      if ({q, gnt, v} !== pack(7 - (i % 8), 1)) begin
        n_bad++;
        $display("FAIL rr_rotation[%0d]: got q=%0d gnt=%h v=%b, want q=%0d v=1", i, q, gnt, v, 7 - (i % 8));
      end
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    drive_cycle(8'h08, 1'b0, 1'b1);
    n_cmp++;
    if ({q, gnt, v} !== pack(3, 1)) begin
      n_bad++;
      $display("FAIL bp_setup: got q=%0d gnt=%h v=%b, want q=3 gnt=08 v=1", q, gnt, v);
    end
    for (int i = 0; i < 4; i++) begin
      drive_cycle(8'h80, 1'b0, 1'b0);
      n_cmp++;
      if ({q, gnt, v} !== pack(3, 1)) begin
        n_bad++;
        $display("FAIL bp_hold[%0d]: got q=%0d gnt=%h v=%b, want q=3 gnt=08 v=1", i, q, gnt, v);
      end
    end
    drive_cycle(8'h80, 1'b0, 1'b1);
    n_cmp++;
    if ({q, gnt, v} !== pack(7, 1)) begin
      n_bad++;
      $display("FAIL bp_release: got q=%0d gnt=%h v=%b, want q=7 gnt=80 v=1", q, gnt, v);
    end
  endtask

  task automatic test_rr_gap();
    int seq [4] = '{3, 0, 3, 0};
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      drive_cycle(8'b0000_1001, 1'b1, 1'b1);
      n_cmp++;
      if ({q, gnt, v} !== pack(seq[i], 1)) begin
        n_bad++;
        $display("FAIL rr_gap_pre[%0d]: got q=%0d gnt=%h v=%b, want q=%0d v=1", i, q, gnt, v, seq[i]);
      end
    end
    drive_cycle('0, 1'b1, 1'b1);
    n_cmp++;
    if ({q, gnt, v} !== pack(0, 0)) begin
      n_bad++;
      $display("FAIL rr_gap_empty: got q=%0d gnt=%h v=%b, want 0/00/0", q, gnt, v);
    end
    for (int i = 0; i < 2; i++) begin
      drive_cycle(8'b0000_1001, 1'b1, 1'b1);
      n_cmp++;
      if ({q, gnt, v} !== pack(seq[i], 1)) begin
        n_bad++;
        $display("FAIL rr_gap_resume[%0d]: got q=%0d gnt=%h v=%b, want q=%0d v=1", i, q, gnt, v, seq[i]);
      end
    end
  endtask

  task automatic test_mode_switch();
    apply_reset();
    drive_cycle(8'b0000_0100, 1'b1, 1'b1);
    drive_cycle(8'b0000_0100, 1'b1, 1'b1);
    n_cmp++;
    if ({q, gnt, v} !== pack(2, 1)) begin
      n_bad++;
      $display("FAIL mode_setup: got q=%0d gnt=%h v=%b, want q=2 gnt=04 v=1", q, gnt, v);
    end
    drive_cycle(8'b0000_0110, 1'b0, 1'b1);
    n_cmp++;
    if ({q, gnt, v} !== pack(2, 1)) begin
      n_bad++;
      $display("FAIL mode_fixed: got q=%0d gnt=%h v=%b, want q=2 gnt=04 v=1", q, gnt, v);
    end
    drive_cycle(8'b0000_0110, 1'b1, 1'b1);
    n_cmp++;
    if ({q, gnt, v} !== pack(1, 1)) begin
      n_bad++;
      $display("FAIL mode_back_rr: got q=%0d gnt=%h v=%b, want q=1 gnt=02 v=1", q, gnt, v);
    end
    // Pointer retention without help from a same-cycle accept: park ptr=2, idle, then RR.
    apply_reset();
    drive_cycle(8'b0000_0100, 1'b1, 1'b1);
    drive_cycle(8'b0000_0100, 1'b1, 1'b1);
    drive_cycle(8'b0000_0110, 1'b0, 1'b1);
    drive_cycle('0, 1'b0, 1'b1);
    drive_cycle(8'b0000_0110, 1'b1, 1'b1);
    n_cmp++;
    if ({q, gnt, v} !== pack(1, 1)) begin
      n_bad++;
      $display("FAIL mode_ptr_retained: got q=%0d gnt=%h v=%b, want q=1 gnt=02 v=1", q, gnt, v);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] r;
    logic [W+N:0] exp;
    apply_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) apply_reset();
      r = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom & $urandom);
      drive_cycle(r, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
      exp = pack(m_q, m_v);
      n_cmp++;
      if ({q, gnt, v} !== exp) begin
        n_bad++;
        $display("FAIL random[%0d]: got q=%0d gnt=%h v=%b, want q=%0d gnt=%h v=%b",
                 i, q, gnt, v, exp[W+N:N+1], exp[N:1], exp[0]);
      end
    end
  endtask

  initial begin
    rst     = 1'b1;
    req     = '0;
    mode    = 1'b0;
    o_ready = 1'b0;
    test_reset();
    test_fixed();
    test_rr_rotation();
    test_backpressure();
    test_rr_gap();
    test_mode_switch();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/prio_arb_rr.md
# prio_arb_rr

Registered N-input priority encoder and arbiter, the parametrised successor of the 4-to-2 combinational priority encoder. Each accepted cycle it encodes a request vector into a binary index, a one-hot grant and a valid flag. It supports fixed-priority (highest index wins) or round-robin mode and has a valid/ready output handshake. It sits between request sources (interrupt lines, channel requesters) and a consumer that may stall.

## Interface
- `N`, default 8: number of request lines; legal values are N ≥ 2.
- `W`, default `$clog2(N)`: width of the index output. Derived; do not override.
- `clk` input, 1 bit: clock. All state updates on the rising edge.
- `rst` input, 1 bit: reset, asynchronous and active-high.
- `req` input, N bits: request vector. Bit i is request i.
- `mode` input, 1 bit: priority mode. 0 = fixed priority; 1 = round-robin.
- `o_ready` input, 1 bit: consumer accepts the current output.
- `q` output, W bits: encoded index of the granted request.
- `gnt` output, N bits: one-hot grant equal to `1 << q` when `v` = 1, otherwise 0.
- `v` output, 1 bit: output valid. Asserted when the captured `req` was non-zero.

## Operation
- **State.** The block holds:
  - an output register `{q, gnt, v}`;
  - a round-robin pointer `ptr`, W bits.
- **Load condition.** `load = !v || o_ready`.
  - When `load` is high, the register captures the encoding of the current `req`.
  - When `load` is low, `q`, `gnt` and `v` hold their values, whatever `req` does.
- **Handshake.** A grant is accepted in any cycle where `v && o_ready`.
- **Fixed mode (`mode` = 0).**
  - The winner is the highest set index, with search order N-1 down to 0.
  - `ptr` does not change.
- **Round-robin mode (`mode` = 1).**
  - Search order is `p-1, p-2, …, 0, N-1, …, p`, wrapping, where `p` is the effective pointer.
  - On an accepted grant in RR mode, `ptr` takes the value of `q`, so the winner becomes lowest priority next.
- **Effective pointer.** `p = (v && o_ready && mode) ? q : ptr`.
  - The search for a new load therefore already accounts for the grant accepted in the same cycle.
  - This prevents the same requester winning twice in succession when other requests are pending.
- **Empty request.** If `req` = 0 on a load:
  - `v` becomes 0, `q` becomes 0 and `gnt` becomes 0;
  - `ptr` is unchanged.
- **Mode change.** A change of `mode` takes effect on the next load. `ptr` is retained across mode switches.
- **Wrap-around.**
  - With `ptr` = 0, RR order is N-1 down to 0, identical to fixed mode.
  - With `ptr` = N-1, RR order starts at N-2.
- **Non-power-of-two N.** `q` never exceeds N-1, and `ptr` only ever holds legal indices.

## Timing
- **Reset.** While `rst` is asserted, the following are 0 immediately (asynchronously): `q`, `gnt`, `v` and `ptr`.
- **Reset mid-operation.**
  - Any pending un-accepted grant is discarded.
  - After release, the first load uses `ptr` = 0.
- **Latency.** One cycle: `req` sampled at edge k appears on `q`, `gnt` and `v` after edge k.
- **Throughput.** One grant per cycle while `o_ready` = 1.
- **Output stability.** Outputs are direct register outputs with no combinational path from `req` to any output.
- **`o_ready` path.** The only input-to-internal combinational path is `o_ready` to the load enable and the effective pointer.

## Structure
- **Package `prio_pkg`.**
  - Mode constants `PRIO_FIXED` = 0 and `PRIO_RR` = 1.
  - A function `rr_order_mask(ptr, N)` that returns the mask of indices below `ptr`.
- **Sub-module `prio_enc_n`.**
  - Parametrised combinational highest-set-bit encoder: N-bit input to W-bit index plus any-set flag.
  - Round-robin is built from two instances:
    - a masked search over `req & mask(p)`;
    - a fallback unmasked search used when the masked result is empty.
- **Top level.** The top holds the load logic, the output register and `ptr`.

## Test plan
1. **Reset.** Assert `rst` mid-stream with `v` = 1 → `q` = 0, `gnt` = 0, `v` = 0 without waiting for a clock edge. Release, then drive `req` = 8'hFF with `mode` = 1 → first `q` = 7.
2. **Fixed mode.** `mode` = 0, `req` = 8'b0010_0110, `o_ready` = 1 → next cycle `q` = 5, `gnt` = 8'b0010_0000, `v` = 1, repeating every cycle while `req` holds.
3. **Round-robin rotation.** `mode` = 1, `req` = 8'hFF constant, `o_ready` = 1 → `q` sequence 7, 6, 5, 4, 3, 2, 1, 0, 7, with exactly one `gnt` bit set in each cycle.
4. **Backpressure.**
   - With `q` = 3 and `v` = 1, hold `o_ready` = 0 for 4 cycles while `req` changes to 8'h80 → `q` = 3 and `v` = 1 are held.
   - Raise `o_ready` → next cycle `q` = 7.
5. **Round-robin fairness with an empty gap.**
   - `mode` = 1, `req` = 8'b0000_1001 → `q` alternates 3, 0, 3, 0.
   - Drive `req` = 0 for one cycle → `v` = 0, `q` = 0, `ptr` unchanged.
   - Drive `req` = 8'b0000_1001 again → the sequence resumes with the index not granted last.
6. **Mode switch.** In RR mode after a grant of `q` = 2 (`ptr` = 2), switch to `mode` = 0 with `req` = 8'b0000_0110 → `q` = 2. Switch back to `mode` = 1 → `q` = 1, since `ptr` was retained.
